// File: rtl/ft_restore.sv
`default_nettype none
// ============================================================================
//  Module      : ft_restore
//  Description : Lockstep recovery engine. On a comparator mismatch it halts
//                both cores, drains their pipelines, copies every shadow-GPR
//                entry into both register files, reloads the saved PC and
//                releases the cores with a one-cycle resume pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ft_restore #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int SKIP_R0      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  resume_o,
  output logic                  busy_o,
  output logic [7:0]            err_count_o
);

  localparam int                  c_num_regs   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_start    = (SKIP_R0 != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(c_num_regs - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam int                  c_cnt_w      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_drain_last = c_cnt_w'(DRAIN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_COPY   = 3'd2,
    S_PC     = 3'd3,
    S_RESUME = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

  // Recovery sequencer; every output is a register updated here.
  // The write to address A is registered on the edge that ends the cycle in
  // which A is presented, so the first write leaves on the last drain edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      sgpr_raddr_o <= '0;
      halt_o       <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      pc_we_o      <= 1'b0;
      pc_o         <= '0;
      resume_o     <= 1'b0;
      busy_o       <= 1'b0;
      err_count_o  <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rf_we_o  <= 1'b0;
      pc_we_o  <= 1'b0;
      resume_o <= 1'b0;
      if (error_i) begin
        // New or repeated mismatch: (re)start the whole pass from the drain.
        // The safe PC is captured only when leaving idle, so an aborted pass
        // keeps restoring the PC of the original fault.
        if (err_count_o != 8'hFF) begin
          err_count_o <= err_count_o + 8'd1;
        end
        if (r_state == S_IDLE) begin
          pc_o <= spc_i;
        end
        r_state      <= S_DRAIN;
        r_cnt        <= '0;
        sgpr_raddr_o <= c_start;
        halt_o       <= 1'b1;
        busy_o       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            halt_o <= 1'b0;
            busy_o <= 1'b0;
          end
          S_DRAIN: begin
            if (r_cnt == c_drain_last) begin
              r_state    <= S_COPY;
              rf_we_o    <= 1'b1;
              rf_waddr_o <= sgpr_raddr_o;
              rf_wdata_o <= sgpr_rdata_i;
              if (sgpr_raddr_o != c_last) begin
                sgpr_raddr_o <= sgpr_raddr_o + c_addr_one;
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          S_COPY: begin
            if (rf_waddr_o == c_last) begin
              // Last register is on the bus this cycle; load the PC next.
              r_state <= S_PC;
              pc_we_o <= 1'b1;
            end else begin
              rf_we_o    <= 1'b1;
              rf_waddr_o <= sgpr_raddr_o;
              rf_wdata_o <= sgpr_rdata_i;
              if (sgpr_raddr_o != c_last) begin
                sgpr_raddr_o <= sgpr_raddr_o + c_addr_one;
              end
            end
          end
          S_PC: begin
            r_state  <= S_RESUME;
            halt_o   <= 1'b0;
            resume_o <= 1'b1;
          end
          S_RESUME: begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            halt_o  <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft_restore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ft_restore
//  Description : Self-checking bench for ft_restore. Two instances (x0 skipped
//                and x0 copied) share stimulus and are compared each cycle
//                against a timeline model of the recovery pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ft_restore;

  localparam int DRAIN = 4;
  localparam int NREG  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err = 1'b0;
  logic [31:0] spc = '0;

  logic [4:0]  raddr_a, waddr_a, raddr_b, waddr_b;
  logic [31:0] rdata_a, wdata_a, pc_a, rdata_b, wdata_b, pc_b;
  logic        halt_a, we_a, pcwe_a, res_a, busy_a;
  logic        halt_b, we_b, pcwe_b, res_b, busy_b;
  logic [7:0]  cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  // model state per instance: cycle index within the current pass (0 = idle)
  int          m_t   [2];
  logic [31:0] m_pc  [2];
  int          m_cnt [2];
  int          res_seen [2];

  typedef struct packed {
    int         inst;
    int         k;
    logic       halt;
    logic       we;
    logic [4:0] waddr;
    logic       pcwe;
    logic       res;
    logic       busy;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  // shadow GPR: combinational read, entry i holds A000_0000 + i
  assign rdata_a = 32'hA000_0000 + 32'(raddr_a);
  assign rdata_b = 32'hA000_0000 + 32'(raddr_b);

  ft_restore u_dut_a (
    .clk_i(clk), .rst_i(rst), .error_i(err), .spc_i(spc),
    .sgpr_raddr_o(raddr_a), .sgpr_rdata_i(rdata_a),
    .halt_o(halt_a), .rf_we_o(we_a), .rf_waddr_o(waddr_a), .rf_wdata_o(wdata_a),
    .pc_we_o(pcwe_a), .pc_o(pc_a), .resume_o(res_a), .busy_o(busy_a),
    .err_count_o(cnt_a)
  );

  ft_restore #(.SKIP_R0(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .error_i(err), .spc_i(spc),
    .sgpr_raddr_o(raddr_b), .sgpr_rdata_i(rdata_b),
    .halt_o(halt_b), .rf_we_o(we_b), .rf_waddr_o(waddr_b), .rf_wdata_o(wdata_b),
    .pc_we_o(pcwe_b), .pc_o(pc_b), .resume_o(res_b), .busy_o(busy_b),
    .err_count_o(cnt_b)
  );

  function automatic int start_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %h, required %h", nm, $time, act, exp);
    end
  endtask

  // Pass timeline: t=1..D drain, D+1..D+N writes, H=D+N+1 PC load, H+1 resume.
  task automatic model_edge(input logic r, input logic e, input logic [31:0] s);
    for (int i = 0; i < 2; i++) begin
      int h;
      h = DRAIN + (NREG - start_of(i)) + 1;
      if (r) begin
        m_t[i] = 0; m_pc[i] = '0; m_cnt[i] = 0;
      end else if (e) begin
        if (m_cnt[i] < 255) m_cnt[i]++;
        if (m_t[i] == 0) m_pc[i] = s;
        m_t[i] = 1;
      end else if (m_t[i] != 0) begin
        m_t[i]++;
        if (m_t[i] > h + 1) m_t[i] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i, input string tag,
                            input logic halt, input logic busy, input logic we,
                            input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic pcwe, input logic [31:0] pc,
                            input logic res, input logic [7:0] cnt);
    int t, s, n, h, a;
    t = m_t[i]; s = start_of(i); n = NREG - s; h = DRAIN + n + 1;
    chk({tag, "_halt"},   32'(halt), 32'((t >= 1) && (t <= h)));
    chk({tag, "_busy"},   32'(busy), 32'((t >= 1) && (t <= h + 1)));
    chk({tag, "_rf_we"},  32'(we),   32'((t >= DRAIN + 1) && (t <= DRAIN + n)));
    chk({tag, "_pc_we"},  32'(pcwe), 32'(t == h));
    chk({tag, "_resume"}, 32'(res),  32'(t == h + 1));
    chk({tag, "_pc"},     pc,        m_pc[i]);
    chk({tag, "_count"},  32'(cnt),  32'(m_cnt[i]));
    if ((t >= DRAIN + 1) && (t <= DRAIN + n)) begin
      a = s + t - DRAIN - 1;
      chk({tag, "_waddr"}, 32'(waddr), 32'(a));
      chk({tag, "_wdata"}, wdata, 32'hA000_0000 + 32'(a));
    end
    if (res === 1'b1) res_seen[i]++;
  endtask

  // Called at a falling edge: drive, clock, update model, check both DUTs.
  task automatic step(input logic r, input logic e, input logic [31:0] s);
    rst = r; err = e; spc = s;
    @(posedge clk);
    model_edge(r, e, s);
    @(negedge clk);
    check_inst(0, "a", halt_a, busy_a, we_a, waddr_a, wdata_a, pcwe_a, pc_a, res_a, cnt_a);
    check_inst(1, "b", halt_b, busy_b, we_b, waddr_b, wdata_b, pcwe_b, pc_b, res_b, cnt_b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cur_k;
    bit  found;
    logic       ah, awe, apw, ar, ab;
    logic [4:0] aw;

    // inst, k, halt, we, waddr, pc_we, resume, busy (k = cycles after error edge)
    tbl[0]  = '{0,  1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[1]  = '{0,  4, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[2]  = '{0,  5, 1'b1, 1'b1, 5'd1,  1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1,  5, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[4]  = '{0, 20, 1'b1, 1'b1, 5'd16, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{0, 35, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{0, 36, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1, 36, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{0, 37, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1, 37, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1};
    tbl[10] = '{0, 38, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1, 38, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    tbl[12] = '{1, 39, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_pc[i] = '0; m_cnt[i] = 0; res_seen[i] = 0;
    end
    @(negedge clk);

    // reset held two cycles with error asserted: everything must be zero
    step(1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b1, 32'h0000_0400);
    chk("rst_raddr_a", 32'(raddr_a), 32'd0);
    chk("rst_waddr_a", 32'(waddr_a), 32'd0);
    chk("rst_wdata_a", wdata_a, 32'd0);
    chk("rst_raddr_b", 32'(raddr_b), 32'd0);
    chk("rst_wdata_b", wdata_b, 32'd0);

    // full restore timeline against the table
    step(1'b0, 1'b1, 32'h0000_0400);
    cur_k = 1;
    for (int j = 0; j < 13; j++) begin
      while (cur_k < tbl[j].k) begin
        step(1'b0, 1'b0, 32'h0);
        cur_k++;
      end
      if (tbl[j].inst == 0) begin
        ah = halt_a; awe = we_a; aw = waddr_a; apw = pcwe_a; ar = res_a; ab = busy_a;
      end else begin
        ah = halt_b; awe = we_b; aw = waddr_b; apw = pcwe_b; ar = res_b; ab = busy_b;
      end
      chk($sformatf("tbl%0d_halt", j),   32'(ah),  32'(tbl[j].halt));
      chk($sformatf("tbl%0d_rf_we", j),  32'(awe), 32'(tbl[j].we));
      chk($sformatf("tbl%0d_pc_we", j),  32'(apw), 32'(tbl[j].pcwe));
      chk($sformatf("tbl%0d_resume", j), 32'(ar),  32'(tbl[j].res));
      chk($sformatf("tbl%0d_busy", j),   32'(ab),  32'(tbl[j].busy));
      if (tbl[j].we) chk($sformatf("tbl%0d_waddr", j), 32'(aw), 32'(tbl[j].waddr));
    end
    chk("full_pc_a", pc_a, 32'h0000_0400);
    chk("full_count_a", 32'(cnt_a), 32'd1);
    chk("full_count_b", 32'(cnt_b), 32'd1);

    // second error during the copy at address 10
    step(1'b1, 1'b0, 32'h0);
    res_seen[0] = 0; res_seen[1] = 0;
    step(1'b0, 1'b1, 32'h0000_0400);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step(1'b0, 1'b0, 32'h0);
      if (we_a === 1'b1 && waddr_a == 5'd10) found = 1'b1;
    end
    chk("abort_reach_addr10", 32'(found), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0999);
    for (int n = 0; n < 45; n++) step(1'b0, 1'b0, 32'h0);
    chk("abort_resume_a", 32'(res_seen[0]), 32'd1);
    chk("abort_resume_b", 32'(res_seen[1]), 32'd1);
    chk("abort_pc_a", pc_a, 32'h0000_0400);
    chk("abort_count_a", 32'(cnt_a), 32'd2);

    // reset during the copy at address 20
    step(1'b1, 1'b0, 32'h0);
    res_seen[0] = 0; res_seen[1] = 0;
    step(1'b0, 1'b1, 32'h0000_0123);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step(1'b0, 1'b0, 32'h0);
      if (we_a === 1'b1 && waddr_a == 5'd20) found = 1'b1;
    end
    chk("rstmid_reach_addr20", 32'(found), 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk("rstmid_halt", 32'(halt_a), 32'd0);
    chk("rstmid_rf_we", 32'(we_a), 32'd0);
    chk("rstmid_busy", 32'(busy_a), 32'd0);
    for (int n = 0; n < 45; n++) step(1'b0, 1'b0, 32'h0);
    chk("rstmid_no_resume_a", 32'(res_seen[0]), 32'd0);
    chk("rstmid_no_resume_b", 32'(res_seen[1]), 32'd0);

    // randomized error/reset traffic against the model
    step(1'b1, 1'b0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0), $urandom);
    end

    // 300 isolated faults, each run to completion: counter saturates
    step(1'b1, 1'b0, 32'h0);
    res_seen[0] = 0; res_seen[1] = 0;
    for (int p = 0; p < 300; p++) begin
      step(1'b0, 1'b1, $urandom);
      for (int n = 0; n < 40; n++) step(1'b0, 1'b0, 32'h0);
    end
    chk("sat_count_a", 32'(cnt_a), 32'd255);
    chk("sat_count_b", 32'(cnt_b), 32'd255);
    chk("sat_resumes_a", 32'(res_seen[0]), 32'd300);
    chk("sat_resumes_b", 32'(res_seen[1]), 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
